noise_gate: RTL and testbench
=============================

NOISE_GATE -- requirements
Module: noise_gate

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port wb_rst_i  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port adc_clock  in  1  sample strobe (level); a sample event is a rising edge of adc_clock detected in the clk domain.
REQ-004 SHALL have port audio_in  in  16  signed sample from the SPI ADC path.
REQ-005 SHALL have port threshold  in  8  open threshold; open_th = {threshold,8'h00}, close_th = {1'b0,threshold,7'h00}.
REQ-006 SHALL have port hold_time  in  8  hold length in sample events.
REQ-007 SHALL have ports attack_step and release_step  in  8 each  gain increment/decrement per sample event.
REQ-008 SHALL have port bypass  in  1  1 = pass sample unattenuated; FSM keeps running.
REQ-009 SHALL have port audio_out  out  16  signed gated sample, feeds compression.
REQ-010 SHALL have port out_valid  out  1  one-clk pulse when audio_out updates.
REQ-011 SHALL have ports gate_open  out  1  (state is OPEN or HOLD) and state  out  3  (CLOSED=0, ATTACK=1, OPEN=2, HOLD=3, RELEASE=4).

Function
REQ-012 SHALL register adc_clock as adc_q; event = adc_clock & ~adc_q.
REQ-013 Edge E (event): SHALL capture audio_in to smp, compute mag = |audio_in| with -32768 saturating to 32767, and update env.
REQ-014 Env update: if mag > env then env = mag, else env = env - (env >> 4); 16-bit unsigned.
REQ-015 Edge E+1: SHALL perform exactly one FSM step and gain update using the env from E.
REQ-016 Gain g SHALL be 9-bit unsigned, range 0..256; 256 = unity.
REQ-017 CLOSED: g = 0; env >= open_th -> ATTACK.
REQ-018 ATTACK: g = min(g + attack_step, 256); g reaching 256 -> OPEN; attack_step = 0 -> g = 256 and OPEN in the same step.
REQ-019 OPEN: g = 256; env < close_th -> HOLD and load hold_cnt = hold_time.
REQ-020 HOLD: env >= open_th -> OPEN; else hold_cnt == 0 -> RELEASE; else hold_cnt decrements; hold_time = 0 -> RELEASE on the first HOLD step.
REQ-021 RELEASE: env >= open_th -> ATTACK with g unchanged; else g = max(g - release_step, 0), and g reaching 0 -> CLOSED; release_step = 0 -> g = 0 and CLOSED.
REQ-022 Edge E+2: SHALL set audio_out = (smp * g) >>> 8 (signed 16 x unsigned 9, 25-bit product, arithmetic shift), using g from E+1; bypass = 1 -> audio_out = smp; out_valid = 1 for that single cycle.
REQ-023 Result SHALL always fit in 16 bits; g = 256 SHALL be exact passthrough.
REQ-024 Latency SHALL be fixed at 3 clk from the adc_clock rise being sampled to out_valid high.
REQ-025 Events SHALL be at least 4 clk apart; closer events are out of spec and SHALL NOT hang the FSM.
REQ-026 threshold, hold_time, step, and bypass changes SHALL take effect at the next event; hold_cnt SHALL NOT reload mid-HOLD.
REQ-027 With no event, all state, env, g, and audio_out SHALL hold.

Reset
REQ-028 wb_rst_i = 1 SHALL set state = CLOSED, env = 0, g = 0, hold_cnt = 0, smp = 0, audio_out = 0, and out_valid = 0.
REQ-029 adc_q SHALL reset to 1, so adc_clock held high through reset release does not produce an event.
REQ-030 Reset asserted mid-pipeline SHALL cancel pending outputs, with no out_valid after reset.
REQ-031 Reset SHALL dominate a coincident event.

Verification
REQ-032 threshold = 8'h10 (open_th = 4096), attack_step = 64, constant audio_in = 8000 -> state CLOSED -> ATTACK at event 1; g = 64, 128, 192, 256; OPEN at event 4; audio_out = 8000 from event 4.
REQ-033 OPEN, hold_time = 3, then audio_in = 0 until env < 2048 -> HOLD for 4 events, then RELEASE; release_step = 128 -> g = 128 then 0; CLOSED; audio_out = 0.
REQ-034 In RELEASE at g = 128, audio_in = 20000 -> ATTACK at the next event with g = 128 + attack_step.
REQ-035 audio_in = -32768 with g = 256 -> audio_out = -32768; mag = 32767; no overflow.
REQ-036 adc_clock held high across reset release -> no out_valid until adc_clock falls and rises; then out_valid exactly 3 clk after the rise.
REQ-037 bypass = 1 in CLOSED with audio_in = 1234 -> audio_out = 1234 and state stays CLOSED while env < open_th.

Source files
------------

// File: rtl/noise_gate.sv
// Noise gate: envelope follower plus a five-state gain FSM that ramps a 9-bit
// gain (256 = unity) and scales each ADC sample; three-clock fixed latency.
module noise_gate (
  input  logic        clk,
  input  logic        wb_rst_i,
  input  logic        adc_clock,
  input  logic [15:0] audio_in,
  input  logic [7:0]  threshold,
  input  logic [7:0]  hold_time,
  input  logic [7:0]  attack_step,
  input  logic [7:0]  release_step,
  input  logic        bypass,
  output logic [15:0] audio_out,
  output logic        out_valid,
  output logic        gate_open,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    ATTACK  = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } st_t;

  st_t         st;
  logic        adc_q;
  logic        ev;
  logic [1:0]  vld_pipe;
  logic [15:0] smp;
  logic [15:0] env;
  logic [15:0] mag;
  logic [8:0]  g;
  logic [7:0]  hold_cnt;
  logic [15:0] open_th;
  logic [15:0] close_th;
  logic [9:0]  atk_sum;
  logic        atk_full;
  logic        rel_zero;
  logic [8:0]  rel_diff;
  logic signed [25:0] smp_x;
  logic signed [25:0] g_x;
  logic signed [25:0] prod;

  assign ev       = adc_clock & ~adc_q;
  assign open_th  = {threshold, 8'h00};
  assign close_th = {1'b0, threshold, 7'h00};

  // -32768 has no positive counterpart; clamp it so the envelope stays 15-bit
  always_comb begin
    mag = audio_in;
    if (audio_in == 16'h8000) mag = 16'h7fff;
    else if (audio_in[15])    mag = ~audio_in + 16'd1;
  end

  assign atk_sum  = {1'b0, g} + {2'b00, attack_step};
  assign atk_full = (attack_step == 8'd0) || (atk_sum >= 10'd256);
  assign rel_zero = (release_step == 8'd0) || (g <= {1'b0, release_step});
  assign rel_diff = g - {1'b0, release_step};

  // g <= 256, so bits [23:8] of the product already hold the shifted result
  assign smp_x = {{10{smp[15]}}, smp};
  assign g_x   = {17'b0, g};
  assign prod  = smp_x * g_x;

  assign gate_open = (st == OPEN) || (st == HOLD);
  assign state     = st;

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      adc_q     <= 1'b1;
      vld_pipe  <= '0;
      smp       <= '0;
      env       <= '0;
      g         <= '0;
      hold_cnt  <= '0;
      st        <= CLOSED;
      audio_out <= '0;
      out_valid <= 1'b0;
    end else begin
      adc_q     <= adc_clock;
      vld_pipe  <= {vld_pipe[0], ev};
      out_valid <= vld_pipe[1];

      if (ev) begin
        smp <= audio_in;
        env <= (mag > env) ? mag : env - (env >> 4);
      end

      if (vld_pipe[0]) begin
        case (st)
          CLOSED: begin
            if (env >= open_th) begin
              // the first attack increment is applied on the opening step
              if (atk_full) begin
                g  <= 9'd256;
                st <= OPEN;
              end else begin
                g  <= atk_sum[8:0];
                st <= ATTACK;
              end
            end else begin
              g <= 9'd0;
            end
          end
          ATTACK: begin
            if (atk_full) begin
              g  <= 9'd256;
              st <= OPEN;
            end else begin
              g <= atk_sum[8:0];
            end
          end
          OPEN: begin
            g <= 9'd256;
            if (env < close_th) begin
              hold_cnt <= hold_time;
              st       <= HOLD;
            end
          end
          HOLD: begin
            if (env >= open_th)        st <= OPEN;
            else if (hold_cnt == 8'd0) st <= RELEASE;
            else                       hold_cnt <= hold_cnt - 8'd1;
          end
          RELEASE: begin
            if (env >= open_th) begin
              st <= ATTACK;
            end else if (rel_zero) begin
              g  <= 9'd0;
              st <= CLOSED;
            end else begin
              g <= rel_diff;
            end
          end
          default: begin
            g  <= 9'd0;
            st <= CLOSED;
          end
        endcase
      end

      if (vld_pipe[1]) audio_out <= bypass ? smp : prod[23:8];
    end
  end

endmodule

// File: tb/tb_noise_gate.sv
// Directed bench for noise_gate: vector table for the open ramp plus
// hand sequences for hold/release, reset and strobe corner cases.
module tb_noise_gate;
  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        adc_clock = 1'b0;
  logic [15:0] audio_in = '0;
  logic [7:0]  threshold = 8'h10;
  logic [7:0]  hold_time = 8'd3;
  logic [7:0]  attack_step = 8'd64;
  logic [7:0]  release_step = 8'd128;
  logic        bypass = 1'b0;
  logic [15:0] audio_out;
  logic        out_valid;
  logic        gate_open;
  logic [2:0]  state;

  localparam int S_CLOSED = 0, S_ATTACK = 1, S_OPEN = 2, S_HOLD = 3, S_RELEASE = 4;

  noise_gate dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .adc_clock(adc_clock), .audio_in(audio_in),
    .threshold(threshold), .hold_time(hold_time), .attack_step(attack_step),
    .release_step(release_step), .bypass(bypass), .audio_out(audio_out),
    .out_valid(out_valid), .gate_open(gate_open), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int env_m = 0;
  int got_out, got_st, got_gate, got_vld, early;

  typedef struct {
    logic [15:0] ain;
    logic        byp;
    int          exp_out;
    int          exp_st;
    int          exp_gate;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic env_upd(input logic [15:0] s);
    int m;
    m = $signed(s);
    if (m < 0) m = -m;
    if (m > 32767) m = 32767;
    if (m > env_m) env_m = m;
    else env_m = env_m - (env_m >> 4);
  endtask

  task automatic do_reset();
    @(negedge clk);
    wb_rst_i = 1'b1;
    repeat (3) @(negedge clk);
    wb_rst_i = 1'b0;
    env_m = 0;
  endtask

  // one sample event; results sampled on the third falling edge after the rise
  task automatic do_event(input logic [15:0] s);
    int ov;
    @(negedge clk);
    audio_in = s;
    adc_clock = 1'b1;
    env_upd(s);
    @(negedge clk);
    ov = int'(out_valid);
    @(negedge clk);
    adc_clock = 1'b0;
    ov = ov | int'(out_valid);
    @(negedge clk);
    got_out  = int'($signed(audio_out));
    got_st   = int'(state);
    got_gate = int'(gate_open);
    got_vld  = int'(out_valid);
    early    = ov;
  endtask

  initial begin
    int n, seen, found;
    vecs[0] = '{16'd1234,            1'b1,   1234, S_CLOSED, 0};
    vecs[1] = '{16'd1234,            1'b0,      0, S_CLOSED, 0};
    vecs[2] = '{16'd8000,            1'b0,   2000, S_ATTACK, 0};
    vecs[3] = '{16'd8000,            1'b0,   4000, S_ATTACK, 0};
    vecs[4] = '{16'd8000,            1'b0,   6000, S_ATTACK, 0};
    vecs[5] = '{16'd8000,            1'b0,   8000, S_OPEN,   1};
    vecs[6] = '{16'h8000,            1'b0, -32768, S_OPEN,   1};
    vecs[7] = '{16'hff9c,            1'b0,   -100, S_OPEN,   1};
    vecs[8] = '{16'd555,             1'b1,    555, S_OPEN,   1};

    // strobe held high through reset release must not create an event
    adc_clock = 1'b1;
    do_reset();
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | int'(out_valid);
    end
    chk("no_event_after_reset", seen, 0);
    adc_clock = 1'b0;
    repeat (2) @(negedge clk);
    adc_clock = 1'b1;
    n = 0;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) begin
        found = 1;
        break;
      end
    end
    chk("latency_clk", found ? n : -1, 3);
    adc_clock = 1'b0;

    do_reset();
    chk("rst_state", int'(state), S_CLOSED);
    chk("rst_audio_out", int'(audio_out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_gate_open", int'(gate_open), 0);

    for (int i = 0; i < 9; i++) begin
      bypass = vecs[i].byp;
      do_event(vecs[i].ain);
      chk($sformatf("vec%0d_out", i), got_out, vecs[i].exp_out);
      chk($sformatf("vec%0d_state", i), got_st, vecs[i].exp_st);
      chk($sformatf("vec%0d_gate", i), got_gate, vecs[i].exp_gate);
      chk($sformatf("vec%0d_valid", i), got_vld & ~early, 1);
    end
    bypass = 1'b0;

    // silence: stay OPEN until the envelope drops below close_th, then hold
    found = 0;
    for (int i = 0; i < 100; i++) begin
      do_event(16'd0);
      chk("decay_state", got_st, (env_m < 2048) ? S_HOLD : S_OPEN);
      if (got_st == S_HOLD || env_m < 2048) begin
        found = 1;
        break;
      end
    end
    chk("hold_reached", found, 1);
    for (int i = 0; i < 3; i++) begin
      do_event(16'd0);
      chk($sformatf("hold%0d_state", i + 1), got_st, S_HOLD);
    end
    do_event(16'd0);
    chk("release_entry_state", got_st, S_RELEASE);
    do_event(16'd0);
    chk("release_g128_state", got_st, S_RELEASE);

    // re-trigger from RELEASE at g=128: gain is kept, then ramps again
    do_event(16'd20000);
    chk("retrig_state", got_st, S_ATTACK);
    chk("retrig_out", got_out, 10000);
    do_event(16'd20000);
    chk("retrig_ramp_state", got_st, S_ATTACK);
    chk("retrig_ramp_out", got_out, 15000);
    do_event(16'd20000);
    chk("retrig_open_state", got_st, S_OPEN);
    chk("retrig_open_out", got_out, 20000);

    // hold_time=0 and release_step=0: immediate release, then straight to CLOSED
    hold_time = 8'd0;
    release_step = 8'd0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      do_event(16'd100);
      if (env_m < 2048) begin
        found = 1;
        break;
      end
    end
    chk("hold0_entry_state", found ? got_st : -1, S_HOLD);
    chk("hold0_entry_out", got_out, 100);
    do_event(16'd100);
    chk("hold0_release_state", got_st, S_RELEASE);
    chk("hold0_release_out", got_out, 100);
    do_event(16'd100);
    chk("rel0_closed_state", got_st, S_CLOSED);
    chk("rel0_closed_out", got_out, 0);

    // attack_step=0 opens fully on the first step
    do_reset();
    attack_step = 8'd0;
    do_event(16'd8000);
    chk("atk0_state", got_st, S_OPEN);
    chk("atk0_out", got_out, 8000);
    attack_step = 8'd64;

    // reset in mid-pipeline cancels the pending output
    @(negedge clk);
    audio_in = 16'd5000;
    adc_clock = 1'b1;
    @(negedge clk);
    wb_rst_i = 1'b1;
    adc_clock = 1'b0;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | int'(out_valid);
    end
    wb_rst_i = 1'b0;
    env_m = 0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | int'(out_valid);
    end
    chk("midrst_no_valid", seen, 0);
    chk("midrst_state", int'(state), S_CLOSED);
    chk("midrst_audio_out", int'(audio_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
